// File: rtl/bnn_act_writeback_pkg.sv
// Shared constants and types for the BNN activation write-back path and the layer FSM.
package bnn_act_writeback_pkg;

  localparam int unsigned WL_DEF   = 112;
  localparam int unsigned AW_DEF   = 5;
  localparam int unsigned POOL_DEF = 4;

  localparam logic MODE_CONV = 1'b0;
  localparam logic MODE_FCL  = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPack  = 2'd1,
    StDrain = 2'd2
  } wb_state_e;

endpackage

// File: rtl/bnn_bin_pool.sv
// Binary max-pool: ORs POOL comparator bits in CONV mode, passes bits straight through in FCL.
module bnn_bin_pool
  import bnn_act_writeback_pkg::*;
#(
  parameter int unsigned POOL = POOL_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic mode_i,
  input  logic en_i,
  input  logic data_i,
  input  logic flush_i,
  output logic commit_o,
  output logic bit_o
);

  localparam int unsigned CW = (POOL > 1) ? $clog2(POOL) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc_q, acc_d;

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    commit_o = 1'b0;
    bit_o    = 1'b0;
    if (mode_i == MODE_FCL) begin
      commit_o = en_i;
      bit_o    = data_i;
    end else begin
      if (en_i) begin
        if (cnt_q == CW'(POOL - 1)) begin
          commit_o = 1'b1;
          bit_o    = acc_q | data_i;
          cnt_d    = '0;
          acc_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          acc_d = acc_q | data_i;
        end
      end
      // A flush after the bit closes out any partial group; a completed group leaves cnt_d at 0.
      if (flush_i && (cnt_d != '0)) begin
        commit_o = 1'b1;
        bit_o    = acc_d;
        cnt_d    = '0;
        acc_d    = 1'b0;
      end
    end
    if (clr_i) begin
      cnt_d = '0;
      acc_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      acc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/bnn_act_writeback.sv
// Activation write-back: pools/packs comparator bits LSB-first into WL-bit words and writes
// them to MEM1 through a single holding register with a ready/enable handshake.
module bnn_act_writeback
  import bnn_act_writeback_pkg::*;
#(
  parameter int unsigned WL   = WL_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned POOL = POOL_DEF
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iCLR,
  input  logic          iSTART,
  input  logic          iMODE,
  input  logic [AW-1:0] iBASE_ADDR,
  input  logic [AW:0]   iNUM_WORDS,
  input  logic          iEN,
  input  logic          iDATA,
  input  logic          iFLUSH,
  input  logic          iWr_READY,
  output logic          oWr_EN,
  output logic [AW-1:0] oWADDR,
  output logic [WL-1:0] oWDATA,
  output logic          oBUSY,
  output logic          oDONE,
  output logic          oOVF
);

  localparam int unsigned PW = $clog2(WL);
  localparam logic [PW-1:0] PtrLast = PW'(WL - 1);

  wb_state_e     state_q, state_d;
  logic          mode_q, mode_d;
  logic [AW:0]   num_words_q, num_words_d;
  logic [AW:0]   issued_q, issued_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [WL-1:0] pack_q, pack_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [WL-1:0] hold_q, hold_d;
  logic          hold_vld_q, hold_vld_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;

  logic          start_act, bit_act, flush_act;
  logic          accept, can_load, load, last_load;
  logic [WL-1:0] load_word;
  logic          pool_commit, pool_bit;

  assign start_act = (state_q == StIdle) && iSTART;
  assign bit_act   = (state_q == StPack) && iEN;
  assign flush_act = (state_q == StPack) && iFLUSH;
  assign accept    = hold_vld_q && iWr_READY;
  assign can_load  = !hold_vld_q || accept;

  bnn_bin_pool #(
    .POOL (POOL)
  ) u_pool (
    .clk_i    (iCLK),
    .rst_i    (iRST),
    .clr_i    (iCLR || start_act),
    .mode_i   (mode_q),
    .en_i     (bit_act),
    .data_i   (iDATA),
    .flush_i  (flush_act),
    .commit_o (pool_commit),
    .bit_o    (pool_bit)
  );

  // Datapath: commit the pooled bit first, then any flush push; at most one load per cycle.
  always_comb begin
    mode_d      = mode_q;
    num_words_d = num_words_q;
    issued_d    = issued_q;
    addr_d      = addr_q;
    pack_d      = pack_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    load        = 1'b0;
    load_word   = '0;

    if (accept) begin
      hold_vld_d = 1'b0;
      addr_d     = addr_q + 1'b1;
    end

    if (pool_commit) begin
      if (ptr_q == PtrLast) begin
        if (can_load) begin
          load              = 1'b1;
          load_word         = pack_q;
          load_word[WL-1]   = pool_bit;
          pack_d            = '0;
          ptr_d             = '0;
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        pack_d[ptr_q] = pool_bit;
        ptr_d         = ptr_q + 1'b1;
      end
    end

    if (flush_act && !load && (ptr_d != '0)) begin
      if (can_load) begin
        load      = 1'b1;
        load_word = pack_d;
        pack_d    = '0;
        ptr_d     = '0;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (load) begin
      hold_d     = load_word;
      hold_vld_d = 1'b1;
      issued_d   = issued_q + 1'b1;
    end

    if ((state_q == StDrain) && accept) done_d = 1'b1;
    if ((state_q == StPack) && (num_words_q == '0)) done_d = 1'b1;

    if (start_act) begin
      mode_d      = iMODE;
      num_words_d = iNUM_WORDS;
      addr_d      = iBASE_ADDR;
      issued_d    = '0;
      pack_d      = '0;
      ptr_d       = '0;
      hold_vld_d  = 1'b0;
    end

    if (iCLR) begin
      mode_d      = MODE_CONV;
      num_words_d = '0;
      issued_d    = '0;
      addr_d      = '0;
      pack_d      = '0;
      ptr_d       = '0;
      hold_d      = '0;
      hold_vld_d  = 1'b0;
      ovf_d       = 1'b0;
      done_d      = 1'b0;
    end
  end

  assign last_load = load && (issued_d == num_words_q);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (iSTART) state_d = StPack;
      StPack: begin
        if (num_words_q == '0) state_d = StIdle;
        else if (last_load)    state_d = StDrain;
      end
      StDrain: if (accept) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (iCLR) state_d = StIdle;
  end

  always_comb begin
    oBUSY  = (state_q != StIdle);
    oWr_EN = hold_vld_q;
    oWADDR = addr_q;
    oWDATA = hold_q;
    oDONE  = done_q;
    oOVF   = ovf_q;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      mode_q      <= MODE_CONV;
      num_words_q <= '0;
      issued_q    <= '0;
      addr_q      <= '0;
      pack_q      <= '0;
      ptr_q       <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      num_words_q <= num_words_d;
      issued_q    <= issued_d;
      addr_q      <= addr_d;
      pack_q      <= pack_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
    end
  end

endmodule
